// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one sync FIFO between NUM_REQ valid/ready producers.
// Define FIFO_WR_ARB_LOCK_EN to enable packet-lock mode (req_last / MAX_BURST / locked).
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 2,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   input  logic                          fifo_full,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          locked
);

   logic [ID_WIDTH-1:0] rr_ptr;
   logic [ID_WIDTH-1:0] win;
   logic [ID_WIDTH-1:0] win_next;
   logic                found;
   logic                xfer;
   logic                lock_hold;
   int                  idx;

`ifdef FIFO_WR_ARB_LOCK_EN
   localparam logic [0:0] ST_ARB  = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [0:0]          state;
   logic [ID_WIDTH-1:0] owner;
   logic [7:0]          beat_cnt;
   logic                burst_end;

   assign lock_hold = (state == ST_LOCK);
   assign locked    = lock_hold;
   assign burst_end = (({1'b0, beat_cnt} + 9'd1) == 9'(MAX_BURST));
`else
   logic unused_cfg;

   assign lock_hold  = 1'b0;
   assign locked     = 1'b0;
   assign unused_cfg = ^{req_last, 8'(MAX_BURST)};
`endif

   // While locked only the owner competes; otherwise scan from rr_ptr upward with wrap.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
`ifdef FIFO_WR_ARB_LOCK_EN
      if (lock_hold) begin
         win   = owner;
         found = req_valid[owner];
      end else begin
`else
      begin
`endif
         for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_REQ;
            if (!found && req_valid[idx]) begin
               found = 1'b1;
               win   = ID_WIDTH'(idx);
            end
         end
      end
   end

   assign xfer      = found & ~fifo_full & rst_n;
   assign req_ready = xfer ? (NUM_REQ'(1) << win) : '0;
   assign fifo_w_en = xfer;
   assign fifo_data = found ? req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign grant_id  = xfer ? win : '0;
   assign win_next  = ID_WIDTH'((int'(win) + 1) % NUM_REQ);

`ifdef FIFO_WR_ARB_LOCK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_ARB;
         rr_ptr   <= '0;
         owner    <= '0;
         beat_cnt <= '0;
      end else if (xfer) begin
         case (state)
            ST_ARB: begin
               if (!req_last[win] && (MAX_BURST > 1)) begin
                  state    <= ST_LOCK;
                  owner    <= win;
                  beat_cnt <= 8'd1;
               end else begin
                  rr_ptr <= win_next;
               end
            end
            default: begin
               if (req_last[owner] || burst_end) begin
                  state    <= ST_ARB;
                  rr_ptr   <= win_next;
                  beat_cnt <= '0;
               end else begin
                  beat_cnt <= beat_cnt + 8'd1;
               end
            end
         endcase
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (xfer)
         rr_ptr <= win_next;
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (4 producers, 8-bit beats).
// Lock-mode scenarios run only when FIFO_WR_ARB_LOCK_EN is defined.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        fifo_w_en;
   logic [7:0]  fifo_data;
   logic        fifo_full;
   logic [1:0]  grant_id;
   logic        locked;

   int n_cmp = 0;
   int n_err = 0;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ID_WIDTH(2), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .fifo_w_en (fifo_w_en),
      .fifo_data (fifo_data),
      .fifo_full (fifo_full),
      .grant_id  (grant_id),
      .locked    (locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Check the four combinational outputs of the current cycle.
   task automatic expect_out(input string tag, input logic [3:0] rdy, input logic wen,
                             input logic [7:0] dat, input logic [1:0] gid);
      #2;
      chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
      chk({tag, ".w_en"},  32'(fifo_w_en), 32'(wen));
      chk({tag, ".data"},  32'(fifo_data), 32'(dat));
      chk({tag, ".gid"},   32'(grant_id),  32'(gid));
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      req_last  = 4'b1111;
      fifo_full = 1'b0;
      #1;

      // Reset held with all producers valid
      for (int c = 0; c < 2; c++) begin
         #2;
         chk("rst.ready", 32'(req_ready), 32'd0);
         chk("rst.w_en",  32'(fifo_w_en), 32'd0);
         chk("rst.locked", 32'(locked), 32'd0);
         tick();
      end
      rst_n = 1'b1;

      // Fairness: ten back-to-back beats rotate 0,1,2,3,0,1,2,3,0,1
      for (int i = 0; i < 10; i++) begin
         expect_out($sformatf("rr%0d", i), 4'(1 << (i % 4)), 1'b1, 8'(8'hA0 + (i % 4)), 2'(i % 4));
         tick();
      end

      // Backpressure with rr_ptr=2: winner shown, nothing accepted
      req_valid = 4'b0100;
      fifo_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         expect_out($sformatf("full%0d", c), 4'b0000, 1'b0, 8'hA2, 2'd0);
         tick();
      end
      fifo_full = 1'b0;
      expect_out("unfull", 4'b0100, 1'b1, 8'hA2, 2'd2);
      tick();

      // rr_ptr must now be 3: req3 beats req0
      req_valid = 4'b1001;
      expect_out("ptr3", 4'b1000, 1'b1, 8'hA3, 2'd3);
      tick();

      // Wrap to 0: req1 wins over req3
      req_valid = 4'b1010;
      expect_out("wrap", 4'b0010, 1'b1, 8'hA1, 2'd1);
      tick();

      // No requester: everything idle, data zero
      req_valid = 4'b0000;
      expect_out("idle", 4'b0000, 1'b0, 8'h00, 2'd0);
      tick();

      // Reset mid-run (rr_ptr=2) returns pointer to 0
      req_valid = 4'b1111;
      rst_n     = 1'b0;
      expect_out("mrst", 4'b0000, 1'b0, 8'hA2, 2'd0);
      tick();
      rst_n = 1'b1;
      expect_out("post", 4'b0001, 1'b1, 8'hA0, 2'd0);
      tick();

`ifndef FIFO_WR_ARB_LOCK_EN
      // req_last has no effect without lock mode
      req_last  = 4'b0000;
      req_valid = 4'b0011;
      expect_out("nolk0", 4'b0010, 1'b1, 8'hA1, 2'd1);
      chk("nolk0.locked", 32'(locked), 32'd0);
      tick();
      expect_out("nolk1", 4'b0001, 1'b1, 8'hA0, 2'd0);
      tick();
      expect_out("nolk2", 4'b0010, 1'b1, 8'hA1, 2'd1);
      chk("nolk2.locked", 32'(locked), 32'd0);
      tick();
`else
      // rr_ptr=1 now; req1 sends 3-beat packet against req0/req2
      req_valid = 4'b0111;
      req_last  = 4'b0000;
      expect_out("pk1", 4'b0010, 1'b1, 8'hA1, 2'd1);
      chk("pk1.locked", 32'(locked), 32'd0);
      tick();
      expect_out("pk2", 4'b0010, 1'b1, 8'hA1, 2'd1);
      chk("pk2.locked", 32'(locked), 32'd1);
      tick();
      req_last = 4'b0010;
      expect_out("pk3", 4'b0010, 1'b1, 8'hA1, 2'd1);
      chk("pk3.locked", 32'(locked), 32'd1);
      tick();
      req_last = 4'b0000;
      expect_out("pkn", 4'b0100, 1'b1, 8'hA2, 2'd2);
      chk("pkn.locked", 32'(locked), 32'd0);
      req_valid = 4'b0000;
      tick();

      // Burst cap: req0 streams with last=0, cap of 4 forces release
      rst_n = 1'b0;
      tick();
      rst_n     = 1'b1;
      req_valid = 4'b0011;
      for (int b = 0; b < 4; b++) begin
         expect_out($sformatf("bc%0d", b), 4'b0001, 1'b1, 8'hA0, 2'd0);
         chk($sformatf("bc%0d.locked", b), 32'(locked), 32'(b != 0));
         tick();
      end
      expect_out("bcn", 4'b0010, 1'b1, 8'hA1, 2'd1);
      chk("bcn.locked", 32'(locked), 32'd0);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
